lookup_table_mc: RTL and testbench

Clocked, multi-channel successor to the cell-rewrite/forwarding lookup table used by the Utopia/ATM receive ports.
- Holds 2^ASIZE entries of DWIDTH bits.
- Entries are written through a single management write port.
- NUM_CH receive channels issue lookups through a req/grant handshake, with round-robin arbitration and a registered, channel-tagged read return.
- After every reset, a hardware init sweep clears the table.

---
 rtl/lut_pkg.sv | 24 ++
 rtl/lookup_table_mc_rr_arbiter.sv | 45 ++++
 rtl/lookup_table_mc.sv | 148 ++++++++++++++
 tb/tb_lookup_table_mc.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/lut_pkg.sv
// Shared types and helpers for the multi-channel lookup table.
// LUT_PARITY_EN adds the parity-extended entry type.
package lut_pkg;

    typedef enum logic {
        INIT,
        RUN
    } lut_state_e;

    // Channel-id width, never below one bit so NUM_CH=1 still has a port.
    function automatic int unsigned lut_ch_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned LUT_MAX_DWIDTH = 64;

`ifdef LUT_PARITY_EN
    typedef struct packed {
        logic                      par;
        logic [LUT_MAX_DWIDTH-1:0] data;
    } lut_pentry_t;
`endif

endpackage

// File: rtl/lookup_table_mc_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant from a rotating pointer.
module rr_arbiter
    import lut_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N-1:0]                 req,
    input  logic                         en,
    output logic [N-1:0]                 gnt,
    output logic [lut_ch_width(N)-1:0]   gnt_id
);

    localparam int unsigned IDW = lut_ch_width(N);

    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] w_idx;
    logic           w_found;

    // Search ascends from the pointer with wrap-around; first requester wins.
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_idx = IDW'((32'(r_ptr) + i) % N);
            if (en && !w_found && req[w_idx]) begin
                w_found    = 1'b1;
                gnt[w_idx] = 1'b1;
                gnt_id     = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

endmodule

// File: rtl/lookup_table_mc.sv
// Multi-channel lookup table with init sweep, management write port and
// round-robin arbitrated reads. Define LUT_PARITY_EN for per-entry parity.
module lookup_table_mc
    import lut_pkg::*;
#(
    parameter int unsigned ASIZE  = 8,
    parameter int unsigned DWIDTH = 16,
    parameter int unsigned NUM_CH = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              wr_en,
    input  logic [ASIZE-1:0]                  wr_addr,
    input  logic [DWIDTH-1:0]                 wr_data,
    output logic                              wr_err,
    input  logic [NUM_CH-1:0]                 rd_req,
    input  logic [NUM_CH*ASIZE-1:0]           rd_addr,
    output logic [NUM_CH-1:0]                 rd_gnt,
    output logic                              rd_valid,
    output logic [lut_ch_width(NUM_CH)-1:0]   rd_ch,
    output logic [DWIDTH-1:0]                 rd_data,
    output logic                              rd_perr,
    output logic                              init_busy
);

    localparam int unsigned CHW   = lut_ch_width(NUM_CH);
    localparam int unsigned DEPTH = 1 << ASIZE;

    lut_state_e        r_state;
    lut_state_e        w_state_nxt;
    logic [ASIZE-1:0]  r_init_cnt;
    logic [DWIDTH-1:0] r_mem [DEPTH];

    logic              w_run;
    logic [ASIZE-1:0]  w_ch_addr [NUM_CH];
    logic [CHW-1:0]    w_gnt_id;
    logic              w_any_gnt;
    logic [ASIZE-1:0]  w_sel_addr;
    logic              w_bypass;
    logic [DWIDTH-1:0] w_sel_data;
    logic              w_par_bad;

    logic              r_rd_valid;
    logic [CHW-1:0]    r_rd_ch;
    logic [DWIDTH-1:0] r_rd_data;
    logic              r_rd_perr;
    logic              r_wr_err;

    assign w_run     = (r_state == RUN);
    assign init_busy = (r_state == INIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= INIT;
            r_init_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == INIT) begin
                r_init_cnt <= r_init_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == INIT && r_init_cnt == '1) begin
            w_state_nxt = RUN;
        end
    end

    rr_arbiter #(
        .N(NUM_CH)
    ) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (rd_req),
        .en     (w_run),
        .gnt    (rd_gnt),
        .gnt_id (w_gnt_id)
    );

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_ch_addr[i] = rd_addr[i*ASIZE +: ASIZE];
        end
    end

    assign w_any_gnt  = |rd_gnt;
    assign w_sel_addr = w_ch_addr[w_gnt_id];
    // Same-cycle write to the granted address is returned write-first.
    assign w_bypass   = w_run && wr_en && (wr_addr == w_sel_addr);
    assign w_sel_data = w_bypass ? wr_data : r_mem[w_sel_addr];

`ifdef LUT_PARITY_EN
    logic r_par [DEPTH];

    always_ff @(posedge clk) begin
        if (r_state == INIT) begin
            r_mem[r_init_cnt] <= '0;
            r_par[r_init_cnt] <= 1'b0;
        end else if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
            r_par[wr_addr] <= ^wr_data;
        end
    end

    assign w_par_bad = w_bypass ? 1'b0 : ((^r_mem[w_sel_addr]) ^ r_par[w_sel_addr]);

    task automatic corrupt(input logic [ASIZE-1:0] addr);
        r_par[addr] = ~r_par[addr];
    endtask
`else
    always_ff @(posedge clk) begin
        if (r_state == INIT) begin
            r_mem[r_init_cnt] <= '0;
        end else if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign w_par_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_ch    <= '0;
            r_rd_data  <= '0;
            r_rd_perr  <= 1'b0;
            r_wr_err   <= 1'b0;
        end else begin
            r_wr_err   <= wr_en && !w_run;
            r_rd_valid <= w_any_gnt;
            r_rd_perr  <= w_any_gnt && w_par_bad;
            if (w_any_gnt) begin
                r_rd_ch   <= w_gnt_id;
                r_rd_data <= w_sel_data;
            end
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_ch    = r_rd_ch;
    assign rd_data  = r_rd_data;
    assign rd_perr  = r_rd_perr;
    assign wr_err   = r_wr_err;

endmodule

// File: tb/tb_lookup_table_mc.sv
// Directed, table-driven bench for lookup_table_mc (ASIZE=8, DWIDTH=16, NUM_CH=4).
module tb_lookup_table_mc;

    localparam int unsigned ASIZE  = 8;
    localparam int unsigned DWIDTH = 16;
    localparam int unsigned NUM_CH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_err;
    logic [3:0]  rd_req;
    logic [31:0] rd_addr;
    logic [3:0]  rd_gnt;
    logic        rd_valid;
    logic [1:0]  rd_ch;
    logic [15:0] rd_data;
    logic        rd_perr;
    logic        init_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lookup_table_mc #(
        .ASIZE (ASIZE),
        .DWIDTH(DWIDTH),
        .NUM_CH(NUM_CH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_err   (wr_err),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_gnt   (rd_gnt),
        .rd_valid (rd_valid),
        .rd_ch    (rd_ch),
        .rd_data  (rd_data),
        .rd_perr  (rd_perr),
        .init_busy(init_busy)
    );

    typedef struct {
        logic        we;
        logic [7:0]  wa;
        logic [15:0] wd;
        logic [3:0]  req;
        logic [31:0] ra;
        logic [3:0]  gnt;
        logic        val;
        logic [1:0]  ch;
        logic [15:0] data;
    } vec_t;

    localparam int NV = 14;
    vec_t v [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Samples once per negedge from release until init_busy drops (bounded).
    task automatic run_init(input bit do_wr, output int n);
        bit gbad;
        gbad = 1'b0;
        n = 0;
        while (init_busy === 1'b1 && n < 400) begin
            if (rd_gnt !== 4'b0000) gbad = 1'b1;
            if (do_wr && n == 11) chk("wr_err_pulse", 32'(wr_err), 32'd1);
            if (do_wr && n == 12) chk("wr_err_clear", 32'(wr_err), 32'd0);
            wr_en   = do_wr && (n == 10);
            wr_addr = 8'h40;
            wr_data = 16'hAAAA;
            n++;
            @(negedge clk);
        end
        wr_en = 1'b0;
        chk("init_no_gnt", 32'(gbad), 32'd0);
        chk("init_cycles", 32'(n), 32'd256);
    endtask

    initial begin
        int n;
        logic [3:0] eg;

        v[0]  = '{1'b0, 8'h00, 16'h0000, 4'b0000, 32'h00000000, 4'b0000, 1'b0, 2'd0, 16'h0000};
        v[1]  = '{1'b1, 8'h0A, 16'h1234, 4'b0000, 32'h00000000, 4'b0000, 1'b0, 2'd0, 16'h0000};
        v[2]  = '{1'b1, 8'h21, 16'h1111, 4'b0100, 32'h000A0000, 4'b0100, 1'b1, 2'd2, 16'h1234};
        v[3]  = '{1'b0, 8'h00, 16'h0000, 4'b0001, 32'h00000040, 4'b0001, 1'b1, 2'd0, 16'h0000};
        v[4]  = '{1'b1, 8'h20, 16'hBEEF, 4'b0010, 32'h00002000, 4'b0010, 1'b1, 2'd1, 16'hBEEF};
        v[5]  = '{1'b1, 8'h22, 16'h2222, 4'b0100, 32'h00210000, 4'b0100, 1'b1, 2'd2, 16'h1111};
        v[6]  = '{1'b0, 8'h00, 16'h0000, 4'b1000, 32'h20000000, 4'b1000, 1'b1, 2'd3, 16'hBEEF};
        v[7]  = '{1'b0, 8'h00, 16'h0000, 4'b1111, 32'h2221200A, 4'b0001, 1'b1, 2'd0, 16'h1234};
        v[8]  = '{1'b0, 8'h00, 16'h0000, 4'b1111, 32'h2221200A, 4'b0010, 1'b1, 2'd1, 16'hBEEF};
        v[9]  = '{1'b0, 8'h00, 16'h0000, 4'b0000, 32'h00000000, 4'b0000, 1'b0, 2'd0, 16'hBEEF};
        v[10] = '{1'b0, 8'h00, 16'h0000, 4'b0011, 32'h0000200A, 4'b0001, 1'b1, 2'd0, 16'h1234};
        v[11] = '{1'b1, 8'hFF, 16'hF00D, 4'b1000, 32'hFF000000, 4'b1000, 1'b1, 2'd3, 16'hF00D};
        v[12] = '{1'b0, 8'h00, 16'h0000, 4'b0001, 32'h000000FF, 4'b0001, 1'b1, 2'd0, 16'hF00D};
        v[13] = '{1'b0, 8'h00, 16'h0000, 4'b0110, 32'h00212200, 4'b0010, 1'b1, 2'd1, 16'h2222};

        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_req  = '0;
        rd_addr = '0;
        repeat (3) @(negedge clk);

        chk("rst_init_busy", 32'(init_busy), 32'd1);
        chk("rst_gnt",       32'(rd_gnt),    32'd0);
        chk("rst_valid",     32'(rd_valid),  32'd0);
        chk("rst_ch",        32'(rd_ch),     32'd0);
        chk("rst_data",      32'(rd_data),   32'd0);
        chk("rst_perr",      32'(rd_perr),   32'd0);
        chk("rst_wr_err",    32'(wr_err),    32'd0);

        // Channel 0 waits through the whole sweep for 0x55.
        rd_req  = 4'b0001;
        rd_addr = 32'h00000055;
        rst_n   = 1'b1;
        run_init(1'b1, n);
        #1 chk("post_init_gnt", 32'(rd_gnt), 32'h1);
        @(negedge clk);
        chk("post_init_valid", 32'(rd_valid), 32'd1);
        chk("post_init_ch",    32'(rd_ch),    32'd0);
        chk("post_init_data",  32'(rd_data),  32'd0);
        rd_req = '0;

        for (int i = 0; i < NV; i++) begin
            wr_en   = v[i].we;
            wr_addr = v[i].wa;
            wr_data = v[i].wd;
            rd_req  = v[i].req;
            rd_addr = v[i].ra;
            #1 chk($sformatf("v%0d_gnt", i), 32'(rd_gnt), 32'(v[i].gnt));
            @(negedge clk);
            chk($sformatf("v%0d_valid", i), 32'(rd_valid), 32'(v[i].val));
            if (v[i].val) chk($sformatf("v%0d_ch", i), 32'(rd_ch), 32'(v[i].ch));
            chk($sformatf("v%0d_data", i), 32'(rd_data), 32'(v[i].data));
            chk($sformatf("v%0d_perr", i), 32'(rd_perr), 32'd0);
        end
        wr_en  = 1'b0;
        rd_req = '0;

        // Reset asserted while a read return is on the outputs.
        rd_req  = 4'b0001;
        rd_addr = 32'h0000000A;
        @(posedge clk);
        #2 chk("prereset_valid", 32'(rd_valid), 32'd1);
        rst_n = 1'b0;
        #1 chk("midrun_rst_valid", 32'(rd_valid), 32'd0);
        chk("midrun_rst_busy", 32'(init_busy), 32'd1);
        rd_req = '0;
        @(negedge clk);

        // All four channels request across the sweep and after it.
        rd_req  = 4'b1111;
        rd_addr = 32'h0A0A0A0A;
        rst_n   = 1'b1;
        run_init(1'b0, n);
        for (int k = 0; k < 8; k++) begin
            eg = 4'b0001 << (k % 4);
            chk($sformatf("rr%0d_gnt", k), 32'(rd_gnt), 32'(eg));
            @(negedge clk);
            chk($sformatf("rr%0d_valid", k), 32'(rd_valid), 32'd1);
            chk($sformatf("rr%0d_ch", k),    32'(rd_ch),    32'(k % 4));
            chk($sformatf("rr%0d_data", k),  32'(rd_data),  32'd0);
        end
        rd_req = '0;
        @(negedge clk);
        chk("rr_idle_valid", 32'(rd_valid), 32'd0);

`ifdef LUT_PARITY_EN
        dut.corrupt(8'h30);
        rd_req  = 4'b0001;
        rd_addr = 32'h00000030;
        @(negedge clk);
        chk("par_bad_valid", 32'(rd_valid), 32'd1);
        chk("par_bad_perr",  32'(rd_perr),  32'd1);
        rd_addr = 32'h00000031;
        @(negedge clk);
        chk("par_ok_valid", 32'(rd_valid), 32'd1);
        chk("par_ok_perr",  32'(rd_perr),  32'd0);
        rd_req = '0;
        @(negedge clk);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
